// File: rtl/fp_pkg.sv
// Shared constants and types for the FP multiplier round/pack path.
// Class codes, exponent limits, canonical NaN and flag bit positions.
package fp_pkg;

  typedef enum logic [1:0] {
    CLS_NORM = 2'b00,
    CLS_ZERO = 2'b01,
    CLS_INF  = 2'b10,
    CLS_NAN  = 2'b11
  } fp_class_e;

  localparam int BIAS = 127;
  localparam logic signed [10:0] EXP_MAX = 11'sd255;
  localparam logic signed [10:0] EXP_MIN = 11'sd0;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG = 31'h7F80_0000;

  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 23-bit fraction with guard/sticky.
// A carry out means the fraction wrapped to zero; exponent must bump.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [22:0] frac,
  input  logic        g,
  input  logic        s,
  output logic [22:0] rnd_frac,
  output logic        carry,
  output logic        inexact
);

  logic round_up;

  // Increment on guard when sticky set or on a tie with odd lsb
  always_comb begin
    round_up            = g & (s | frac[0]);
    {carry, rnd_frac}   = {1'b0, frac} + {23'd0, round_up};
    inexact             = g | s;
  end

endmodule

// File: rtl/fp_mul_round_pack.sv
// Two-stage normalize / round / pack back end for an FP32 multiplier.
// S1 picks the frac window and GRS bits; S2 rounds, range-checks, packs.
module fp_mul_round_pack
  import fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [9:0]       in_exp,
  input  logic [47:0]      in_man,
  input  logic [1:0]       in_class,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [2:0]       out_flags,
  output logic [CNT_W-1:0] ovf_count
);

  logic                s1_valid;
  logic                s1_sign;
  logic signed [10:0]  s1_exp;
  logic [22:0]         s1_frac;
  logic                s1_g;
  logic                s1_s;
  fp_class_e           s1_class;

  logic                s2_adv;
  logic                s1_adv;

  logic signed [10:0]  n_exp;
  logic [22:0]         n_frac;
  logic                n_g;
  logic                n_s;

  logic [22:0]         rnd_frac;
  logic                rnd_carry;
  logic                rnd_inx;
  logic signed [10:0]  f_exp;
  logic [31:0]         p_result;
  logic [2:0]          p_flags;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Normalize: select fraction window by product msb, derive G and S
  always_comb begin
    n_exp  = {in_exp[9], in_exp};
    n_frac = in_man[45:23];
    n_g    = in_man[22];
    n_s    = |in_man[21:0];
    if (in_man[47]) begin
      n_exp  = {in_exp[9], in_exp} + 11'sd1;
      n_frac = in_man[46:24];
      n_g    = in_man[23];
      n_s    = |in_man[22:0];
    end
  end

  // Stage 1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
      s1_class <= CLS_NORM;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign  <= in_sign;
        s1_exp   <= n_exp;
        s1_frac  <= n_frac;
        s1_g     <= n_g;
        s1_s     <= n_s;
        s1_class <= fp_class_e'(in_class);
      end
    end
  end

  fp_round_rne u_rnd (
    .frac     (s1_frac),
    .g        (s1_g),
    .s        (s1_s),
    .rnd_frac (rnd_frac),
    .carry    (rnd_carry),
    .inexact  (rnd_inx)
  );

  // Range check and pack; specials bypass rounding with clean flags
  always_comb begin
    f_exp    = s1_exp + $signed({10'd0, rnd_carry});
    p_result = '0;
    p_flags  = '0;
    unique case (s1_class)
      CLS_ZERO: p_result = {s1_sign, 31'd0};
      CLS_INF:  p_result = {s1_sign, INF_MAG};
      CLS_NAN:  p_result = QNAN;
      default: begin
        if (f_exp >= EXP_MAX) begin
          p_result           = {s1_sign, INF_MAG};
          p_flags[FLAG_OVF]  = 1'b1;
          p_flags[FLAG_INX]  = 1'b1;
        end else if (f_exp <= EXP_MIN) begin
          p_result           = {s1_sign, 31'd0};
          p_flags[FLAG_UNF]  = 1'b1;
          p_flags[FLAG_INX]  = 1'b1;
        end else begin
          p_result           = {s1_sign, f_exp[7:0], rnd_frac};
          p_flags[FLAG_INX]  = rnd_inx;
        end
      end
    endcase
  end

  // Stage 2 register: holds result while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= p_result;
        out_flags  <= p_flags;
      end
    end
  end

  // Saturating count of delivered overflow results
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (out_valid && out_ready && out_flags[FLAG_OVF]
                 && (ovf_count != {CNT_W{1'b1}})) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Directed-vector bench for fp_mul_round_pack.
// Expected results are hand-computed IEEE-754 encodings.
module tb_fp_mul_round_pack;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_man;
  logic [1:0]  in_class;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic [15:0] ovf_count;

  int n_vec;
  int n_bad;

  fp_mul_round_pack #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_man     (in_man),
    .in_class   (in_class),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .ovf_count  (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [9:0] e,
                       input logic [47:0] m, input logic [1:0] c);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_man   = m;
    in_class = c;
  endtask

  task automatic vec(input string tag, input logic s, input logic [9:0] e,
                     input logic [47:0] m, input logic [1:0] c,
                     input logic [31:0] res, input logic [2:0] flg);
    int lat;
    lat = -1;
    drive(s, e, m, c);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_res"}, out_result, res);
    chk({tag, "_flg"}, 32'(out_flags), 32'(flg));
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_man    = '0;
    in_class  = 2'b00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ovld", 32'(out_valid), 32'd0);
    chk("rst_rdy",  32'(in_ready),  32'd1);
    chk("rst_cnt",  32'(ovf_count), 32'd0);
    chk("rst_res",  out_result,     32'd0);
    chk("rst_flg",  32'(out_flags), 32'd0);
    @(posedge clk);
    #1;

    vec("v2p25", 1'b0, 10'd127, 48'h9000_0000_0000, 2'b00,
        32'h4010_0000, 3'b000);
    vec("tie_ev", 1'b0, 10'd127, 48'h4000_0040_0000, 2'b00,
        32'h3F80_0000, 3'b001);
    vec("tie_od", 1'b0, 10'd127, 48'h4000_00C0_0000, 2'b00,
        32'h3F80_0002, 3'b001);
    vec("carry", 1'b0, 10'd127, 48'h7FFF_FFC0_0000, 2'b00,
        32'h4000_0000, 3'b001);
    vec("ovf", 1'b0, 10'd255, 48'h4000_0000_0000, 2'b00,
        32'h7F80_0000, 3'b101);
    chk("cnt1", 32'(ovf_count), 32'd1);
    vec("unf", 1'b1, 10'd0, 48'h4000_0000_0000, 2'b00,
        32'h8000_0000, 3'b011);
    vec("rc_ovf", 1'b1, 10'd254, 48'h7FFF_FFC0_0000, 2'b00,
        32'hFF80_0000, 3'b101);
    chk("cnt2", 32'(ovf_count), 32'd2);
    vec("neg_exp", 1'b0, 10'h3F6, 48'h4000_0000_0000, 2'b00,
        32'h0000_0000, 3'b011);
    vec("top_e", 1'b0, 10'd254, 48'h4000_0000_0000, 2'b00,
        32'h7F00_0000, 3'b000);
    vec("zero", 1'b1, 10'd300, 48'hFFFF_FFFF_FFFF, 2'b01,
        32'h8000_0000, 3'b000);
    vec("inf", 1'b0, 10'd5, 48'h1234_5678_9ABC, 2'b10,
        32'h7F80_0000, 3'b000);
    vec("nan", 1'b1, 10'd127, 48'h8000_0000_0001, 2'b11,
        32'h7FC0_0000, 3'b000);

    // backpressure: three offered, two held
    out_ready = 1'b0;
    drive(1'b0, 10'd127, 48'h9000_0000_0000, 2'b00);
    @(posedge clk);
    #1 drive(1'b0, 10'd127, 48'h4000_0000_0000, 2'b00);
    @(posedge clk);
    #1 drive(1'b1, 10'd127, 48'h4000_0000_0000, 2'b00);
    @(posedge clk);
    #1;
    chk("bp_rdy",  32'(in_ready),  32'd0);
    chk("bp_ovld", 32'(out_valid), 32'd1);
    chk("bp_res0", out_result,     32'h4010_0000);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_res1", out_result, 32'h4010_0000);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_a", out_result, 32'h4010_0000);
    @(posedge clk);
    #1;
    chk("bp_bv", 32'(out_valid), 32'd1);
    chk("bp_b",  out_result,     32'h3F80_0000);
    @(posedge clk);
    #1;
    chk("bp_end", 32'(out_valid), 32'd0);

    // reset with both stages full
    out_ready = 1'b0;
    drive(1'b0, 10'd127, 48'h9000_0000_0000, 2'b00);
    @(posedge clk);
    #1 drive(1'b0, 10'd127, 48'h4000_0000_0000, 2'b00);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("full_rdy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mr_ovld", 32'(out_valid), 32'd0);
    chk("mr_cnt",  32'(ovf_count), 32'd0);
    chk("mr_rdy",  32'(in_ready),  32'd1);
    chk("mr_flg",  32'(out_flags), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_idle", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_mul_round_pack.md
FP_MUL_ROUND_PACK -- requirements
Module: fp_mul_round_pack

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the saturating overflow event counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: upstream product is valid.
REQ-005 SHALL have port in_ready, output, 1: block accepts the product this cycle.
REQ-006 SHALL have port in_sign, input, 1: XOR of operand signs.
REQ-007 SHALL have port in_exp, input, 10: signed two's-complement biased exponent sum (expA+expB-127).
REQ-008 SHALL have port in_man, input, 48: raw 24x24 mantissa product, hidden bits included.
REQ-009 SHALL have port in_class, input, 2: 00 normal, 01 zero, 10 inf, 11 NaN (upstream-resolved).
REQ-010 SHALL have port out_valid, input/output: output, 1: packed result valid.
REQ-011 SHALL have port out_ready, input, 1: downstream consumes the result.
REQ-012 SHALL have port out_result, output, 32: IEEE-754 single result.
REQ-013 SHALL have port out_flags, output, 3: {overflow, underflow, inexact}.
REQ-014 SHALL have port ovf_count, output, CNT_W: saturating count of overflow results delivered.

Function
REQ-015 SHALL be a 2-stage pipeline (S1 normalize/GRS, S2 round/range/pack); latency 2 cycles from in_valid&&in_ready to out_valid with out_ready high; throughput 1 per cycle.
REQ-016 SHALL advance S2 when !s2_valid||out_ready; S1 when !s1_valid||S2 advance; in_ready = S1 advance.
REQ-017 SHALL hold out_result/out_flags stable while out_valid&&!out_ready; no result dropped or duplicated.
REQ-018 S1 SHALL, if in_man[47]: frac=man[46:24], G=man[23], S=|man[22:0], e=in_exp+1; else frac=man[45:23], G=man[22], S=|man[21:0], e=in_exp.
REQ-019 S2 SHALL round to nearest even: round_up = G&(S|frac[0]); inexact = G|S.
REQ-020 SHALL, on frac carry-out after rounding, set frac=0 and e=e+1.
REQ-021 SHALL, when final e>=255, output sign|0x7F800000 with overflow=1, inexact=1.
REQ-022 SHALL, when final e<=0, flush to signed zero (sign<<31) with underflow=1, inexact=1.
REQ-023 SHALL, for class zero, output signed zero; inf, signed inf; NaN, 0x7FC00000; flags all 0 for specials.
REQ-024 SHALL increment ovf_count on out_valid&&out_ready&&overflow flag, saturating at all-ones.
REQ-025 SHALL use 11-bit signed internal exponent arithmetic so in_exp+2 never wraps.

Reset
REQ-026 SHALL clear s1_valid, s2_valid, out_valid, out_result, out_flags and ovf_count to 0 on rst, including mid-operation; in-flight data discarded.
REQ-027 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-028 SHALL place class encodings, bias 127, exp max 255, canonical NaN 0x7FC00000 and flag bit indices in shared package fp_pkg.
REQ-029 SHALL implement RNE rounding plus carry handling as sub-module fp_round_rne (23-bit frac, G, S in; frac, carry, inexact out).

Verification
REQ-030 sign 0, exp 127, man 0x900000000000 -> 0x40100000 (2.25) two cycles later, flags 000.
REQ-031 exp 127, man 0x400000400000 -> 0x3F800000, inexact; man 0x400000C00000 -> 0x3F800002, inexact.
REQ-032 exp 127, man 0x7FFFFFC00000 -> 0x40000000 (round carry), inexact.
REQ-033 exp 255, man 0x400000000000 -> 0x7F800000, flags 101, ovf_count 1; sign 1, exp 0 -> 0x80000000, flags 011.
REQ-034 out_ready low, 3 back-to-back inputs -> 2 accepted, in_ready low, output stable; out_ready high -> both delivered in order.
REQ-035 rst asserted with both stages full -> next cycle out_valid 0, ovf_count 0, in_ready 1.
